sram_req_ctrl: RTL

Valid/ready request front-end placed directly upstream of the single-port synchronous SRAM (`cs`/`we`/`ad`/`din`/`dout`, one-cycle registered read).
- Accepts read and write requests from a streaming master and drives the SRAM control pins.
- Absorbs the SRAM's one-cycle read latency.
- Returns read data in order through a 2-entry response FIFO with full backpressure.
- Sustains one request per cycle when the response side is not stalled.

---
 rtl/sram_req_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sram_req_ctrl.sv
// ----------------------------------------------------------------------------
// sram_req_ctrl
//
// Valid/ready request front-end for a single-port synchronous SRAM with a
// one-cycle registered read. Requests are turned into SRAM pin activity in
// the same cycle they are accepted. Read data returns in order through a
// 2-entry response FIFO. Backpressure is credit based: a new request is only
// accepted while the FIFO plus the read in flight still leaves space for it.
//
// Optional feature macro: SRAM_REQ_CTRL_ADDR_CHK_EN
//   When defined, requests with req_addr_i >= DEPTH are accepted but never
//   reach the SRAM. Such writes are dropped. Such reads still take a response
//   slot, so ordering is preserved, and return data 0 with rsp_err_o = 1.
//   When undefined, addresses pass unchecked and rsp_err_o is always 0.
//
// Ports
//   clk_i        clock, all state on the rising edge
//   rst_ni       asynchronous active-low reset
//   req_valid_i  request present
//   req_ready_o  request accepted when req_valid_i & req_ready_o at an edge
//   req_we_i     1 = write, 0 = read
//   req_addr_i   word address
//   req_wdata_i  write data
//   rsp_valid_o  read response available at FIFO head
//   rsp_ready_i  consumer takes the head response
//   rsp_rdata_o  head read data
//   rsp_err_o    head response flags an out-of-range address
//   sram_cs_o    SRAM chip select
//   sram_we_o    SRAM write enable
//   sram_ad_o    SRAM address
//   sram_din_o   SRAM write data
//   sram_dout_i  SRAM read data, valid the cycle after a read is issued
// ----------------------------------------------------------------------------
module sram_req_ctrl #(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 32,
    parameter int DEPTH_LOG = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [DEPTH_LOG-1:0] req_addr_i,
    input  logic [WIDTH-1:0]     req_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [WIDTH-1:0]     rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 sram_cs_o,
    output logic                 sram_we_o,
    output logic [DEPTH_LOG-1:0] sram_ad_o,
    output logic [WIDTH-1:0]     sram_din_o,
    input  logic [WIDTH-1:0]     sram_dout_i
);

    logic             acc;
    logic             pop;
    logic             push;
    logic             addr_bad;
    logic [1:0]       occ_after_pop;
    logic [WIDTH-1:0] push_data;

    logic             inflight_q,     inflight_d;
    logic             inflight_err_q, inflight_err_d;
    logic [1:0]       count_q,        count_d;
    logic             wr_ptr_q,       wr_ptr_d;
    logic             rd_ptr_q,       rd_ptr_d;
    logic [WIDTH-1:0] data_q [2];
    logic [1:0]       err_q;

`ifdef SRAM_REQ_CTRL_ADDR_CHK_EN
    localparam logic [DEPTH_LOG:0] DEPTH_W = (DEPTH_LOG+1)'(DEPTH);
    assign addr_bad = ({1'b0, req_addr_i} >= DEPTH_W);
`else
    assign addr_bad = 1'b0;
`endif

    // Slots still claimed after this cycle's pop: queued entries plus the
    // read whose data lands next edge. Never exceeds 2 while the credit rule
    // holds, so 2 bits suffice and pop cannot underflow (pop needs count>0).
    assign occ_after_pop = count_q + {1'b0, inflight_q} - {1'b0, pop};
    assign req_ready_o   = rst_ni & (occ_after_pop < 2'd2);

    assign acc  = req_valid_i & req_ready_o;
    assign pop  = rsp_valid_o & rsp_ready_i;
    assign push = inflight_q;

    assign sram_cs_o  = acc & ~addr_bad;
    assign sram_we_o  = acc & req_we_i & ~addr_bad;
    assign sram_ad_o  = req_addr_i;
    assign sram_din_o = req_wdata_i;

    // An unissued read never touched the SRAM, so its dout is stale.
    assign push_data = inflight_err_q ? '0 : sram_dout_i;

    always_comb begin
        inflight_d     = acc & ~req_we_i;
        inflight_err_d = acc & ~req_we_i & addr_bad;
        wr_ptr_d       = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d       = pop  ? ~rd_ptr_q : rd_ptr_q;
        count_d        = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q     <= 1'b0;
            inflight_err_q <= 1'b0;
            count_q        <= 2'd0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            data_q[0]      <= '0;
            data_q[1]      <= '0;
            err_q          <= 2'b00;
        end else begin
            inflight_q     <= inflight_d;
            inflight_err_q <= inflight_err_d;
            count_q        <= count_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            if (push) begin
                data_q[wr_ptr_q] <= push_data;
                err_q[wr_ptr_q]  <= inflight_err_q;
            end
        end
    end

    assign rsp_valid_o = (count_q != 2'd0);
    assign rsp_rdata_o = data_q[rd_ptr_q];
    assign rsp_err_o   = err_q[rd_ptr_q];

    // The credit rule guarantees a full FIFO has nothing in flight.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && count_q == 2'd2));

endmodule
